telemetry_rx: RTL

Receive end of the e-bike telemetry link. Deserializes the UART stream on RX (8N1, LSB first, idle high) and parses each 8-byte telemetry packet: 0xAA, 0x55, batt_v[11:8], batt_v[7:0], avg_curr[11:8], avg_curr[7:0], avg_torque[11:8], avg_torque[7:0]. Publishes the three 12-bit values with a one-cycle ready pulse. Sits on the display/logging board and in the bench loopback against the telemetry transmitter.

---
 rtl/telemetry_rx.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/telemetry_rx.sv
// Telemetry link receiver: 8N1 UART deserializer feeding a packet parser that
// publishes battery voltage, average current and average torque (12 bits each).
module telemetry_rx #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_rdy,
  output logic        pkt_err
);

  // Reload with BAUD_DIV-1 so a down-count ending at zero spans exactly BAUD_DIV clocks.
  localparam logic [11:0] HALF_CNT = 12'(BAUD_DIV / 2);
  localparam logic [11:0] BIT_CNT  = 12'(BAUD_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [1:0] P_HUNT_AA = 2'd0;
  localparam logic [1:0] P_HUNT_55 = 2'd1;
  localparam logic [1:0] P_PAYLOAD = 2'd2;

  function automatic logic [11:0] join12(input logic [3:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

  logic        rx_meta_q, rx_s_q, rx_prev_q;
  logic [1:0]  st_q, st_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        byte_vld_q, byte_vld_d;
  logic        frm_err_q, frm_err_d;

  logic [1:0]  pst_q, pst_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  batt_hi_q, batt_hi_d;
  logic [7:0]  batt_lo_q, batt_lo_d;
  logic [3:0]  curr_hi_q, curr_hi_d;
  logic [7:0]  curr_lo_q, curr_lo_d;
  logic [3:0]  torq_hi_q, torq_hi_d;
  logic [11:0] batt_v_q, batt_v_d;
  logic [11:0] avg_curr_q, avg_curr_d;
  logic [11:0] avg_torque_q, avg_torque_d;
  logic        pkt_rdy_q, pkt_rdy_d;
  logic        pkt_err_q, pkt_err_d;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    byte_vld_d = 1'b0;
    frm_err_d  = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          st_d  = S_START;
          cnt_d = HALF_CNT;
        end
      end
      S_START: begin
        if (cnt_q == 12'd0) begin
          if (!rx_s_q) begin
            st_d  = S_DATA;
            cnt_d = BIT_CNT;
            bit_d = 3'd0;
          end else begin
            st_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 12'd0) begin
          sh_d  = {rx_s_q, sh_q[7:1]};
          cnt_d = BIT_CNT;
          if (bit_q == 3'd7) st_d = S_STOP;
          else               bit_d = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == 12'd0) begin
          if (rx_s_q) byte_vld_d = 1'b1;
          else        frm_err_d  = 1'b1;
          st_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 12'd1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= S_IDLE;
      cnt_q      <= 12'd0;
      bit_q      <= 3'd0;
      sh_q       <= 8'd0;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
      byte_vld_q <= byte_vld_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // Packet parser: sh_q stays stable while byte_vld_q is high since the byte FSM is idle.
  always_comb begin
    pst_d        = pst_q;
    idx_d        = idx_q;
    batt_hi_d    = batt_hi_q;
    batt_lo_d    = batt_lo_q;
    curr_hi_d    = curr_hi_q;
    curr_lo_d    = curr_lo_q;
    torq_hi_d    = torq_hi_q;
    batt_v_d     = batt_v_q;
    avg_curr_d   = avg_curr_q;
    avg_torque_d = avg_torque_q;
    pkt_rdy_d    = 1'b0;
    pkt_err_d    = 1'b0;
    if (frm_err_q) begin
      if (pst_q != P_HUNT_AA) begin
        pkt_err_d = 1'b1;
        pst_d     = P_HUNT_AA;
      end
    end else if (byte_vld_q) begin
      case (pst_q)
        P_HUNT_AA: begin
          if (sh_q == 8'hAA) pst_d = P_HUNT_55;
        end
        P_HUNT_55: begin
          if (sh_q == 8'h55) begin
            pst_d = P_PAYLOAD;
            idx_d = 3'd0;
          end else if (sh_q != 8'hAA) begin
            pkt_err_d = 1'b1;
            pst_d     = P_HUNT_AA;
          end
        end
        P_PAYLOAD: begin
          if (!idx_q[0] && (sh_q[7:4] != 4'd0)) begin
            pkt_err_d = 1'b1;
            pst_d     = P_HUNT_AA;
          end else begin
            idx_d = idx_q + 3'd1;
            case (idx_q)
              3'd0: batt_hi_d = sh_q[3:0];
              3'd1: batt_lo_d = sh_q;
              3'd2: curr_hi_d = sh_q[3:0];
              3'd3: curr_lo_d = sh_q;
              3'd4: torq_hi_d = sh_q[3:0];
              default: begin
                batt_v_d     = join12(batt_hi_q, batt_lo_q);
                avg_curr_d   = join12(curr_hi_q, curr_lo_q);
                avg_torque_d = join12(torq_hi_q, sh_q);
                pkt_rdy_d    = 1'b1;
                pst_d        = P_HUNT_AA;
                idx_d        = 3'd0;
              end
            endcase
          end
        end
        default: pst_d = P_HUNT_AA;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pst_q        <= P_HUNT_AA;
      idx_q        <= 3'd0;
      batt_hi_q    <= 4'd0;
      batt_lo_q    <= 8'd0;
      curr_hi_q    <= 4'd0;
      curr_lo_q    <= 8'd0;
      torq_hi_q    <= 4'd0;
      batt_v_q     <= 12'd0;
      avg_curr_q   <= 12'd0;
      avg_torque_q <= 12'd0;
      pkt_rdy_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
    end else begin
      pst_q        <= pst_d;
      idx_q        <= idx_d;
      batt_hi_q    <= batt_hi_d;
      batt_lo_q    <= batt_lo_d;
      curr_hi_q    <= curr_hi_d;
      curr_lo_q    <= curr_lo_d;
      torq_hi_q    <= torq_hi_d;
      batt_v_q     <= batt_v_d;
      avg_curr_q   <= avg_curr_d;
      avg_torque_q <= avg_torque_d;
      pkt_rdy_q    <= pkt_rdy_d;
      pkt_err_q    <= pkt_err_d;
    end
  end

  assign batt_v     = batt_v_q;
  assign avg_curr   = avg_curr_q;
  assign avg_torque = avg_torque_q;
  assign pkt_rdy    = pkt_rdy_q;
  assign pkt_err    = pkt_err_q;

endmodule
